// File: rtl/sw_rr_if.sv
// Packet switch port bundle: per-port input stream, per-port output stream and drop counter.
// The switch connects as slave; the traffic source/sink connects as master.
interface sw_rr_if #(
   parameter int NPORT = 4,
   parameter int DW    = 16
);
   localparam int DSTW = $clog2(NPORT);
   localparam int PW   = DSTW + DW;

   logic [NPORT-1:0]    in_valid;
   logic [NPORT*PW-1:0] in_data;
   logic [NPORT-1:0]    in_ready;
   logic [NPORT-1:0]    out_valid;
   logic [NPORT*PW-1:0] out_data;
   logic [NPORT-1:0]    out_ready;
   logic [7:0]          drop_cnt;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, drop_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, drop_cnt
   );
endinterface

// File: rtl/sw_rr.sv
// NPORT x NPORT input-buffered packet switch: per-input FIFO, per-output round-robin
// arbiter and registered valid/ready output stage; unroutable heads are dropped and counted.
module sw_rr #(
   parameter int NPORT = 4,
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input logic   clk,
   input logic   rst,
   sw_rr_if.slave bus
);
   localparam int DSTW = $clog2(NPORT);
   localparam int PW   = DSTW + DW;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam logic [DSTW:0] NPORT_W = (DSTW+1)'(NPORT);

   logic [PW-1:0]    mem_q      [NPORT][DEPTH];
   logic [PW-1:0]    mem_d      [NPORT][DEPTH];
   logic [AW-1:0]    wr_ptr_q   [NPORT];
   logic [AW-1:0]    wr_ptr_d   [NPORT];
   logic [AW-1:0]    rd_ptr_q   [NPORT];
   logic [AW-1:0]    rd_ptr_d   [NPORT];
   logic [CW-1:0]    cnt_q      [NPORT];
   logic [CW-1:0]    cnt_d      [NPORT];
   logic [DSTW-1:0]  ptr_q      [NPORT];
   logic [DSTW-1:0]  ptr_d      [NPORT];
   logic [PW-1:0]    out_data_q [NPORT];
   logic [PW-1:0]    out_data_d [NPORT];
   logic [NPORT-1:0] out_valid_q;
   logic [NPORT-1:0] out_valid_d;
   logic [7:0]       drop_cnt_q;
   logic [7:0]       drop_cnt_d;

   logic [NPORT-1:0] full;
   logic [NPORT-1:0] nempty;
   logic [NPORT-1:0] push;
   logic [NPORT-1:0] drop;
   logic [NPORT-1:0] pop;
   logic [NPORT-1:0] slot_free;
   logic [NPORT-1:0] grant_vld;
   logic [DSTW-1:0]  grant_idx [NPORT];
   logic [PW-1:0]    head      [NPORT];
   logic [DSTW-1:0]  head_dst  [NPORT];
   logic [NPORT-1:0] req       [NPORT];
   logic [DSTW:0]    scan_idx;
   logic [8:0]       drop_sum;

   // Occupancy comes from the registered count only, so a full FIFO never accepts
   // a push even when it pops in the same cycle.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         full[i]     = (cnt_q[i] == CW'(DEPTH));
         nempty[i]   = (cnt_q[i] != '0);
         head[i]     = mem_q[i][rd_ptr_q[i]];
         head_dst[i] = head[i][PW-1 -: DSTW];
         drop[i]     = nempty[i] & ({1'b0, head_dst[i]} >= NPORT_W);
         push[i]     = bus.in_valid[i] & ~full[i] & ~rst;
      end
   end

   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         for (int i = 0; i < NPORT; i++) begin
            req[j][i] = nempty[i] & ~drop[i] & (head_dst[i] == DSTW'(j));
         end
      end
   end

   // Round-robin scan starting at ptr_q[j], wrapping modulo NPORT.
   always_comb begin
      scan_idx = '0;
      for (int j = 0; j < NPORT; j++) begin
         grant_vld[j] = 1'b0;
         grant_idx[j] = '0;
         slot_free[j] = ~out_valid_q[j] | bus.out_ready[j];
         for (int off = 0; off < NPORT; off++) begin
            scan_idx = {1'b0, ptr_q[j]} + (DSTW+1)'(off);
            if (scan_idx >= NPORT_W) begin
               scan_idx = scan_idx - NPORT_W;
            end
            if (slot_free[j] && !grant_vld[j] && req[j][scan_idx[DSTW-1:0]]) begin
               grant_vld[j] = 1'b1;
               grant_idx[j] = scan_idx[DSTW-1:0];
            end
         end
      end
   end

   always_comb begin
      pop = drop;
      for (int j = 0; j < NPORT; j++) begin
         if (grant_vld[j]) begin
            pop[grant_idx[j]] = 1'b1;
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < NPORT; i++) begin
         cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = bus.in_data[i*PW +: PW];
         end
      end
   end

   // Output stage: load on grant, clear on accept without new grant, otherwise hold.
   always_comb begin
      out_valid_d = out_valid_q;
      for (int j = 0; j < NPORT; j++) begin
         out_data_d[j] = out_data_q[j];
         ptr_d[j]      = ptr_q[j];
         if (grant_vld[j]) begin
            out_valid_d[j] = 1'b1;
            out_data_d[j]  = {grant_idx[j], head[grant_idx[j]][DW-1:0]};
            ptr_d[j]       = (grant_idx[j] == DSTW'(NPORT-1)) ? '0 : grant_idx[j] + 1'b1;
         end else if (bus.out_ready[j]) begin
            out_valid_d[j] = 1'b0;
         end
      end
   end

   always_comb begin
      drop_sum = {1'b0, drop_cnt_q};
      for (int i = 0; i < NPORT; i++) begin
         drop_sum = drop_sum + 9'(drop[i]);
      end
      drop_cnt_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         out_valid_q <= '0;
         drop_cnt_q  <= '0;
         for (int i = 0; i < NPORT; i++) begin
            wr_ptr_q[i]   <= '0;
            rd_ptr_q[i]   <= '0;
            cnt_q[i]      <= '0;
            ptr_q[i]      <= '0;
            out_data_q[i] <= '0;
         end
      end else begin
         out_valid_q <= out_valid_d;
         drop_cnt_q  <= drop_cnt_d;
         for (int i = 0; i < NPORT; i++) begin
            wr_ptr_q[i]   <= wr_ptr_d[i];
            rd_ptr_q[i]   <= rd_ptr_d[i];
            cnt_q[i]      <= cnt_d[i];
            ptr_q[i]      <= ptr_d[i];
            out_data_q[i] <= out_data_d[i];
         end
      end
   end

   assign bus.in_ready  = ~full & {NPORT{~rst}};
   assign bus.out_valid = out_valid_q;
   assign bus.drop_cnt  = drop_cnt_q;

   for (genvar g = 0; g < NPORT; g++) begin : g_out
      assign bus.out_data[g*PW +: PW] = out_data_q[g];
   end
endmodule
